// File: rtl/alu_trace_buffer_if.sv
// Read-side port of the ALU trace buffer: head entry presented with valid/ready.
interface alu_trace_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6,
    parameter int CHANNELS   = 2,
    parameter int TS_WIDTH   = 16
);
    localparam int CHB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [CHB-1:0]        rd_channel;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] rd_out;
    logic [OP_WIDTH-1:0]   rd_op;
    logic [TS_WIDTH-1:0]   rd_ts;

    // Trace buffer side
    modport master (
        output rd_valid, rd_channel, rd_a, rd_b, rd_out, rd_op, rd_ts,
        input  rd_ready
    );

    // Consumer side
    modport slave (
        input  rd_valid, rd_channel, rd_a, rd_b, rd_out, rd_op, rd_ts,
        output rd_ready
    );
endinterface

// File: rtl/alu_trace_buffer.sv
// Capture buffer for ALU issue/result events: snoops CHANNELS ALU ports, stores one
// timestamped event per cycle in a circular buffer, drains first-word-fall-through.
module alu_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    localparam int CHB       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNTB      = $clog2(DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cfg_wrap,
    input  logic                           arm,
    input  logic                           disarm,
    input  logic [CHANNELS-1:0]            ch_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_a,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_b,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_out,
    input  logic [CHANNELS*OP_WIDTH-1:0]   ch_op,
    alu_trace_buffer_if.master             rd,
    output logic [CNTB-1:0]                count,
    output logic                           overflow,
    output logic [15:0]                    dropped,
    output logic [1:0]                     state
);
    localparam int PTRB = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    typedef struct packed {
        logic [CHB-1:0]        ch;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] out;
        logic [OP_WIDTH-1:0]   op;
        logic [TS_WIDTH-1:0]   ts;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PTRB-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRB-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTB-1:0] count_q, count_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [CHB-1:0]  rr_q, rr_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     dropped_q, dropped_d;
    state_e          state_q, state_d;

    logic            any_valid;
    logic [CHB-1:0]  grant;
    int unsigned     n_valid;
    logic            push, pop, ovw;
    int unsigned     lost;
    int unsigned     sum;
    entry_t          head;

    // Round-robin grant: first valid channel at or after the rr pointer
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        n_valid   = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            int unsigned idx;
            idx = (32'(rr_q) + k) % CHANNELS;
            n_valid = n_valid + 32'(ch_valid[k]);
            if (ch_valid[idx] && !any_valid) begin
                any_valid = 1'b1;
                grant     = idx[CHB-1:0];
            end
        end
    end

    // Next-state: FSM, push/pop/overwrite, drop accounting
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ts_d       = ts_q;
        rr_d       = rr_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        mem_d      = mem_q;
        push       = 1'b0;
        pop        = 1'b0;
        ovw        = 1'b0;
        lost       = 0;
        sum        = 0;

        if (disarm) begin
            // disarm beats a simultaneous arm; contents kept and still drainable
            state_d = ST_IDLE;
            pop     = (count_q != '0) && rd.rd_ready;
        end else if (arm) begin
            state_d    = ST_CAPTURE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ts_d       = '0;
            rr_d       = '0;
            overflow_d = 1'b0;
            dropped_d  = '0;
        end else begin
            pop = (count_q != '0) && rd.rd_ready;
            if (state_q != ST_IDLE) begin
                ts_d = ts_q + 1'b1;
            end
            if (state_q == ST_FULL) begin
                lost = n_valid;
            end else if (state_q == ST_CAPTURE && any_valid) begin
                lost = n_valid - 1;
                if (count_q == CNTB'(DEPTH) && !pop && !cfg_wrap) begin
                    lost    = lost + 1;
                    state_d = ST_FULL;
                end else begin
                    push = 1'b1;
                    // full without a pop in wrap mode: oldest entry is overwritten
                    ovw  = (count_q == CNTB'(DEPTH)) && !pop;
                    if (ovw) begin
                        lost = lost + 1;
                    end
                    rr_d = (grant == CHB'(CHANNELS - 1)) ? '0 : grant + 1'b1;
                end
            end
        end

        if (push) begin
            mem_d[wr_ptr_q].ch  = grant;
            mem_d[wr_ptr_q].a   = ch_a[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
            mem_d[wr_ptr_q].b   = ch_b[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
            mem_d[wr_ptr_q].out = ch_out[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
            mem_d[wr_ptr_q].op  = ch_op[32'(grant)*OP_WIDTH +: OP_WIDTH];
            mem_d[wr_ptr_q].ts  = ts_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop || ovw) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !ovw && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (state_d == ST_CAPTURE && !cfg_wrap && count_d == CNTB'(DEPTH)) begin
            state_d = ST_FULL;
        end

        if (lost != 0) begin
            overflow_d = 1'b1;
            sum        = 32'(dropped_q) + lost;
            dropped_d  = (sum > 32'hFFFF) ? 16'hFFFF : sum[15:0];
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            rr_q       <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            mem_q      <= mem_d;
        end
    end

    // Head entry shown combinationally; all fields zero when empty
    always_comb begin
        head          = mem_q[rd_ptr_q];
        rd.rd_valid   = (count_q != '0);
        rd.rd_channel = rd.rd_valid ? head.ch  : '0;
        rd.rd_a       = rd.rd_valid ? head.a   : '0;
        rd.rd_b       = rd.rd_valid ? head.b   : '0;
        rd.rd_out     = rd.rd_valid ? head.out : '0;
        rd.rd_op      = rd.rd_valid ? head.op  : '0;
        rd.rd_ts      = rd.rd_valid ? head.ts  : '0;
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;
    assign state    = state_q;
endmodule
